x_seq_div: RTL and testbench
============================

X_SEQ_DIV -- requirements
Module: x_seq_div

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 resetn  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  dividend/divisor present this cycle.
REQ-005 in_ready  output  1  block can accept an operand pair.
REQ-006 dividend  input  WIDTH  numerator.
REQ-007 divisor  input  WIDTH  denominator.
REQ-008 out_valid  output  1  quotient/remainder/div_by_zero valid.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 quotient  output  WIDTH  result quotient.
REQ-011 remainder  output  WIDTH  result remainder.
REQ-012 div_by_zero  output  1  current result came from a zero divisor.

Function
REQ-013 FSM states SHALL be IDLE, CALC and DONE; no other reachable states.
REQ-014 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-015 Acceptance SHALL occur on a rising edge with in_valid=1 and in_ready=1; operands SHALL be latched at that edge and not sampled again.
REQ-016 IDLE->CALC on acceptance with divisor!=0; IDLE->DONE on acceptance with divisor=0.
REQ-017 CALC SHALL run restoring shift-subtract, one quotient bit per cycle, MSB first, for exactly WIDTH cycles, then go to DONE.
REQ-018 Latency: out_valid SHALL rise WIDTH+1 cycles after the acceptance edge (nonzero divisor), 1 cycle after it (zero divisor).
REQ-019 Unsigned results: quotient=floor(dividend/divisor), remainder=dividend-quotient*divisor, both exact in WIDTH bits.
REQ-020 Zero divisor: quotient=all ones, remainder=dividend, div_by_zero=1; otherwise div_by_zero=0.
REQ-021 In DONE, quotient/remainder/div_by_zero SHALL hold stable while out_ready=0 (no timeout).
REQ-022 DONE->IDLE on a rising edge with out_ready=1; in_ready SHALL be 1 the following cycle (no same-cycle result/operand overlap).
REQ-023 in_valid toggling during CALC or DONE SHALL be ignored; out_ready outside DONE SHALL be ignored.
REQ-024 Outputs quotient/remainder SHALL be registered; no combinational path from any input to any output.

Reset
REQ-025 resetn=0 SHALL asynchronously force state=IDLE, in_ready=1 after release, out_valid=0, quotient=0, remainder=0, div_by_zero=0, internal counters/accumulators=0.
REQ-026 Reset asserted during CALC or DONE SHALL abort the operation; the pending result SHALL never appear.
REQ-027 First acceptance SHALL be possible on the first rising edge after resetn deasserts.

Configuration
REQ-028 Macro X_SEQ_DIV_SIGNED_EN: when defined, operands SHALL be two's complement; divide magnitudes, quotient truncates toward zero, remainder takes the dividend's sign; latency unchanged; sign fix-up SHALL be applied on the CALC->DONE edge.
REQ-029 With X_SEQ_DIV_SIGNED_EN: most-negative/-1 SHALL give quotient=dividend, remainder=0, div_by_zero=0; zero divisor SHALL give quotient=all ones, remainder=dividend.
REQ-030 Without X_SEQ_DIV_SIGNED_EN: unsigned-only behaviour per REQ-019/020, no sign logic synthesized; port list identical in both builds.

Verification (WIDTH=8)
REQ-031 Unsigned 200/7, out_ready=1 -> out_valid high 9 cycles after accept, quotient=28, remainder=4, div_by_zero=0.
REQ-032 55/0 -> out_valid 1 cycle after accept, quotient=255, remainder=55, div_by_zero=1.
REQ-033 255/1 accepted, out_ready held 0 for 5 cycles in DONE -> quotient=255, remainder=0 stable throughout; in_ready=0 until cycle after out_ready=1.
REQ-034 Accept 100/3, drop resetn at 4th CALC cycle, release, accept 9/4 -> only result seen is quotient=2, remainder=1.
REQ-035 SIGNED_EN build: 0xF9/0x02 (-7/2) -> quotient=0xFD, remainder=0xFF; 0x80/0xFF -> quotient=0x80, remainder=0x00.
REQ-036 Back-to-back: in_valid held 1 with 3 operand pairs, out_ready=1 -> three results in order, each accept exactly one cycle after preceding DONE exit.

Source files
------------

// File: rtl/x_seq_div.sv
// ---------------------------------------------------------------------------
// x_seq_div : sequential restoring divider, one quotient bit per clock.
//
// Purpose
//   Accepts a dividend/divisor pair with a valid/ready handshake, runs a
//   restoring shift-subtract for WIDTH cycles (MSB first) and presents
//   quotient, remainder and a divide-by-zero flag until the consumer takes
//   them. A zero divisor skips the iteration and completes immediately with
//   quotient = all ones and remainder = dividend.
//
// Configuration macro
//   X_SEQ_DIV_SIGNED_EN : when defined, operands are two's complement. The
//   magnitudes are divided, the quotient truncates toward zero and the
//   remainder takes the dividend's sign. The sign correction is folded into
//   the CALC->DONE edge, so latency matches the unsigned build. The port
//   list is identical in both builds.
//
// Ports
//   clk          rising-edge clock
//   resetn       asynchronous active-low reset
//   in_valid     operand pair present
//   in_ready     block is idle and can accept an operand pair
//   dividend     numerator   [WIDTH-1:0]
//   divisor      denominator [WIDTH-1:0]
//   out_valid    quotient/remainder/div_by_zero are valid
//   out_ready    consumer accepts the result
//   quotient     result quotient  [WIDTH-1:0]
//   remainder    result remainder [WIDTH-1:0]
//   div_by_zero  current result came from a zero divisor
// ---------------------------------------------------------------------------
module x_seq_div #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  // acc: partial remainder; shf: dividend bits shift out at the top while
  // quotient bits shift in at the bottom; dsr: latched divisor (magnitude).
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] shf_q, shf_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             fits;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] shf_next;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dsr_mag;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

`ifdef X_SEQ_DIV_SIGNED_EN
  logic neg_quo_q, neg_quo_d;
  logic neg_rem_q, neg_rem_d;
`endif

  // One restoring step: bring down the next dividend bit, try to subtract
  // the divisor and keep the difference only when it does not go negative.
  always_comb begin
    trial    = {acc_q, shf_q[WIDTH-1]};
    diff     = trial - {1'b0, dsr_q};
    fits     = ~diff[WIDTH];
    acc_next = fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    shf_next = {shf_q[WIDTH-2:0], fits};
  end

  // Operand magnitudes and final sign correction. The unsigned build passes
  // everything straight through so no sign logic exists there.
  always_comb begin
`ifdef X_SEQ_DIV_SIGNED_EN
    dvd_mag = dividend[WIDTH-1] ? (~dividend + WIDTH'(1)) : dividend;
    dsr_mag = divisor[WIDTH-1]  ? (~divisor  + WIDTH'(1)) : divisor;
    quo_fix = neg_quo_q ? (~shf_next + WIDTH'(1)) : shf_next;
    rem_fix = neg_rem_q ? (~acc_next + WIDTH'(1)) : acc_next;
`else
    dvd_mag = dividend;
    dsr_mag = divisor;
    quo_fix = shf_next;
    rem_fix = acc_next;
`endif
  end

  // Next-state and datapath control for the IDLE/CALC/DONE sequence.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    acc_d   = acc_q;
    shf_d   = shf_q;
    dsr_d   = dsr_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
`ifdef X_SEQ_DIV_SIGNED_EN
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (divisor == '0) begin
            // Zero divisor completes at the acceptance edge.
            state_d = DONE;
            quo_d   = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = CALC;
            count_d = '0;
            acc_d   = '0;
            shf_d   = dvd_mag;
            dsr_d   = dsr_mag;
            dbz_d   = 1'b0;
`ifdef X_SEQ_DIV_SIGNED_EN
            neg_quo_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_rem_d = dividend[WIDTH-1];
`endif
          end
        end
      end
      CALC: begin
        acc_d   = acc_next;
        shf_d   = shf_next;
        count_d = count_q + CW'(1);
        // The last step writes the corrected result straight to the outputs.
        if (count_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          quo_d   = quo_fix;
          rem_d   = rem_fix;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All state lives here; reset clears every register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      count_q <= '0;
      acc_q   <= '0;
      shf_q   <= '0;
      dsr_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
`ifdef X_SEQ_DIV_SIGNED_EN
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      acc_q   <= acc_d;
      shf_q   <= shf_d;
      dsr_q   <= dsr_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
`ifdef X_SEQ_DIV_SIGNED_EN
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
`endif
    end
  end

  // Handshake flags are decoded from the state register only.
  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_x_seq_div.sv
// ---------------------------------------------------------------------------
// tb_x_seq_div : self-checking bench for x_seq_div (WIDTH = 8).
//
// A scoreboard queue holds the result every accepted operand pair must
// produce, computed with plain integer division, together with the cycle
// in which it must become visible. A monitor on the falling edge compares
// the handshake flags and result outputs against that queue every cycle.
// Directed tests then compare the captured results with hand-computed
// literals. Works with or without X_SEQ_DIV_SIGNED_EN defined.
// ---------------------------------------------------------------------------
module tb_x_seq_div;

  localparam int W = 8;

  logic         clk;
  logic         resetn;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  x_seq_div #(.WIDTH(W)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    int           acc;
    int           ready;
    bit           seen;
  } exp_t;

  exp_t sb[$];

  int vectors = 0;
  int fails   = 0;
  int cyc     = 0;

  int           result_count = 0;
  logic [W-1:0] last_q;
  logic [W-1:0] last_r;
  logic         last_z;
  int           last_lat     = 0;
  int           last_exit    = -1;
  int           last_accept  = -1;
  bit           b2b_mode     = 1'b0;
  int           b2b_n        = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference result from the arithmetic rules alone.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int acc_cyc);
    exp_t e;
    int   qi, ri;
    e.acc  = acc_cyc;
    e.seen = 1'b0;
    if (b == '0) begin
      e.q     = '1;
      e.r     = a;
      e.z     = 1'b1;
      e.ready = acc_cyc;
    end else begin
`ifdef X_SEQ_DIV_SIGNED_EN
      qi = int'($signed(a)) / int'($signed(b));
      ri = int'($signed(a)) % int'($signed(b));
`else
      qi = int'(a) / int'(b);
      ri = int'(a) % int'(b);
`endif
      e.q     = W'(qi);
      e.r     = W'(ri);
      e.z     = 1'b0;
      e.ready = acc_cyc + W;
    end
    return e;
  endfunction

  // Monitor: inputs change just after the rising edge, so values seen here
  // are what the next rising edge will act on.
  always @(negedge clk) begin
    bit exp_valid;
    exp_t e;
    if (!resetn) begin
      sb.delete();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_quotient", 32'(quotient), 32'd0);
      chk("rst_remainder", 32'(remainder), 32'd0);
      chk("rst_dbz", 32'(div_by_zero), 32'd0);
    end else begin
      exp_valid = (sb.size() > 0) && (cyc >= sb[0].ready);
      chk("out_valid", 32'(out_valid), 32'(exp_valid));
      chk("in_ready", 32'(in_ready), 32'(sb.size() == 0));
      if (out_valid && exp_valid) begin
        chk("quotient", 32'(quotient), 32'(sb[0].q));
        chk("remainder", 32'(remainder), 32'(sb[0].r));
        chk("div_by_zero", 32'(div_by_zero), 32'(sb[0].z));
        if (!sb[0].seen) begin
          sb[0].seen = 1'b1;
          last_lat   = cyc - sb[0].acc + 1;
        end
        if (out_ready) begin
          last_q    = quotient;
          last_r    = remainder;
          last_z    = div_by_zero;
          last_exit = cyc + 1;
          result_count++;
          void'(sb.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        e = model(dividend, divisor, cyc + 1);
        sb.push_back(e);
        last_accept = cyc + 1;
        if (b2b_mode) begin
          if (b2b_n > 0) chk("b2b_accept_gap", 32'(last_accept - last_exit), 32'd1);
          b2b_n++;
        end
      end
    end
  end

  // Present an operand pair and wait (bounded) until it is accepted.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input bit keep);
    int n;
    @(posedge clk); #1;
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(in_ready && resetn) && n < 200);
    if (n >= 200) chk("accept_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(sb.size() == 0 && in_ready) && n < 200);
    if (n >= 200) chk("drain_timeout", 32'd1, 32'd0);
  endtask

  task automatic checkOutput(input string name, input logic [W-1:0] q, input logic [W-1:0] r,
                             input logic z, input int lat);
    chk({name, "_q"}, 32'(last_q), 32'(q));
    chk({name, "_r"}, 32'(last_r), 32'(r));
    chk({name, "_z"}, 32'(last_z), 32'(z));
    if (lat > 0) chk({name, "_lat"}, 32'(last_lat), 32'(lat));
  endtask

  initial begin
    int r0;
    int rel;
    int n;
    logic [W-1:0] tq, tr;
    resetn    = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;

`ifdef X_SEQ_DIV_SIGNED_EN
    applyStimulus(8'hF9, 8'h02, 1'b0); waitIdle();
    checkOutput("s_m7_2", 8'hFD, 8'hFF, 1'b0, 9);
    applyStimulus(8'h80, 8'hFF, 1'b0); waitIdle();
    checkOutput("s_min_m1", 8'h80, 8'h00, 1'b0, 9);
    applyStimulus(8'h07, 8'hFE, 1'b0); waitIdle();
    checkOutput("s_7_m2", 8'hFD, 8'h01, 1'b0, 9);
    applyStimulus(8'h85, 8'h00, 1'b0); waitIdle();
    checkOutput("s_div0", 8'hFF, 8'h85, 1'b1, 1);
`else
    applyStimulus(8'd200, 8'd7, 1'b0); waitIdle();
    checkOutput("u_200_7", 8'd28, 8'd4, 1'b0, 9);
`endif

    // Zero divisor: immediate completion.
    applyStimulus(8'd55, 8'd0, 1'b0); waitIdle();
    checkOutput("div0", 8'd255, 8'd55, 1'b1, 1);

    // Result held while out_ready is low; in_valid noise is ignored.
    out_ready = 1'b0;
    applyStimulus(8'd255, 8'd1, 1'b0);
    n = 0;
    while (!out_valid && n < 50) begin @(posedge clk); n++; end
    if (n >= 50) chk("hold_timeout", 32'd1, 32'd0);
    #1;
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      dividend = 8'(i * 37);
      divisor  = 8'd0;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    waitIdle();
    checkOutput("hold_255_1", 8'd255, 8'd0, 1'b0, 9);

    // Reset in the 4th CALC cycle aborts; first edge after release accepts.
    r0 = result_count;
    applyStimulus(8'd100, 8'd3, 1'b0);
    repeat (3) @(posedge clk);
    #1 resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    dividend = 8'd9;
    divisor  = 8'd4;
    in_valid = 1'b1;
    resetn   = 1'b1;
    rel      = cyc;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("first_accept_after_reset", 32'(last_accept), 32'(rel + 1));
    waitIdle();
    chk("abort_result_count", 32'(result_count - r0), 32'd1);
    checkOutput("abort_9_4", 8'd2, 8'd1, 1'b0, 9);

    // Back-to-back with in_valid held high.
    b2b_mode = 1'b1;
    b2b_n    = 0;
    applyStimulus(8'd17, 8'd5, 1'b1);
    applyStimulus(8'd250, 8'd16, 1'b1);
    applyStimulus(8'd8, 8'd9, 1'b0);
    waitIdle();
    b2b_mode = 1'b0;
    chk("b2b_count", 32'(b2b_n), 32'd3);
    checkOutput("b2b_8_9", 8'd0, 8'd8, 1'b0, 9);

    // A few boundary operands.
    applyStimulus(8'd0, 8'd5, 1'b0); waitIdle();
    checkOutput("zero_num", 8'd0, 8'd0, 1'b0, 9);
    applyStimulus(8'd3, 8'd200, 1'b0); waitIdle();
`ifdef X_SEQ_DIV_SIGNED_EN
    tq = 8'h00; tr = 8'h03;
`else
    tq = 8'd0;  tr = 8'd3;
`endif
    checkOutput("small_num", tq, tr, 1'b0, 9);
    applyStimulus(8'd255, 8'd255, 1'b0); waitIdle();
    checkOutput("equal_ops", 8'd1, 8'd0, 1'b0, 9);
    applyStimulus(8'd128, 8'd2, 1'b0); waitIdle();
`ifdef X_SEQ_DIV_SIGNED_EN
    tq = 8'hC0; tr = 8'h00;
`else
    tq = 8'd64; tr = 8'd0;
`endif
    checkOutput("msb_num", tq, tr, 1'b0, 9);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails + 1);
    $finish;
  end

endmodule
